vga_frame_capture: RTL and testbench

Downstream consumer of the sync-recovery VGA controller. Takes its `display_col`/`display_row`/`visible` outputs together with the incoming RGB444 pixel stream, and decimates each 800x600 frame by 2 in both axes to 400x300. Retained pixels are buffered in a small FIFO and streamed to the framebuffer writer over a valid/ready interface, each with a linear address.

---
 rtl/vga_frame_capture.sv | 154 +++++++++++++++
 tb/tb_vga_frame_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// ============================================================================
// Module   : vga_frame_capture
// Brief    : 2x2 decimating frame grabber feeding a valid/ready framebuffer FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_frame_capture #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 17,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int LW        = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       display_col,
  input  logic [10:0]       display_row,
  input  logic              visible,
  input  logic [11:0]       pixel_in,
  input  logic              capture_en,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              overflow,
  output logic [LW-1:0]     fifo_level
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int EW = ADDR_W + 12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_vis_prev;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_smp_valid;
  logic [ADDR_W-1:0]   r_smp_addr;
  logic [11:0]         r_smp_data;
  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [PW:0]         r_wptr;
  logic [PW:0]         r_rptr;
  logic                r_overflow;
  logic                r_frame_done;

  logic                w_fall;
  logic                w_sample;
  logic [LW-1:0]       w_level;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_drop;
  logic [EW-1:0]       w_head;
  logic                w_unused;

  assign w_unused  = ^display_col;

  assign w_fall    = r_vis_prev & ~visible;
  assign w_sample  = (r_state == S_CAPTURE) && visible && !r_x[0] && !r_y[0] &&
                     (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));

  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == LW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && wr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = r_smp_valid && (!w_full || w_pop);
  assign w_drop    = r_smp_valid && w_full && !w_pop;

  assign w_head     = r_mem[r_rptr[PW-1:0]];
  assign wr_valid   = !w_empty;
  assign wr_addr    = w_empty ? '0 : w_head[EW-1:12];
  assign wr_data    = w_empty ? '0 : w_head[11:0];
  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wptr[PW-1:0]] <= {r_smp_addr, r_smp_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_vis_prev   <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_smp_valid  <= 1'b0;
      r_smp_addr   <= '0;
      r_smp_data   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vis_prev   <= visible;
      r_frame_done <= 1'b0;
      // Samples are staged one cycle, so a retained pixel reaches the head two edges later.
      r_smp_valid  <= w_sample;
      if (w_sample) begin
        r_smp_addr <= r_addr;
        r_smp_data <= pixel_in;
        r_addr     <= r_addr + 1'b1;
      end
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_drop)    r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (capture_en && (display_row == '0)) begin
            r_state <= S_CAPTURE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
          end
        end
        S_CAPTURE: begin
          if (w_fall) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
            if (r_y == YW'(V_ACTIVE - 1)) r_state <= S_DRAIN;
          end else if (visible && (r_x < XW'(H_ACTIVE))) begin
            r_x <= r_x + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_empty && !r_smp_valid) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_capture.sv
// ============================================================================
// Module   : tb_vga_frame_capture
// Brief    : Scenario-table bench for vga_frame_capture on a reduced 16x6 frame
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_frame_capture;

  localparam int H    = 16;
  localparam int V    = 6;
  localparam int FD   = 4;
  localparam int AW   = 5;
  localparam int HB   = 4;
  localparam int LINE = H + HB;
  localparam int ROWS = V + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   display_col;
  logic [10:0]   display_row;
  logic          visible;
  logic [11:0]   pixel_in;
  logic          capture_en;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic          overflow;
  logic [2:0]    fifo_level;

  vga_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(FD), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .display_col(display_col),
    .display_row(display_row), .visible(visible), .pixel_in(pixel_in),
    .capture_en(capture_en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Write monitor: sampled on the falling edge, midway between active edges.
  int q_addr[$];
  int q_data[$];
  int done_cnt = 0;
  int peak     = 0;

  always @(negedge clock) begin
    if (wr_valid && wr_ready) begin
      q_addr.push_back(int'(wr_addr));
      q_data.push_back(int'(wr_data));
    end
    if (frame_done) done_cnt++;
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  typedef struct {
    int pre_rst;  // pulse reset before the frame
    int cap;      // capture_en at frame start
    int cap_row;  // row where capture_en rises (-1: never)
    int rdy;      // 0: always ready, 1: stalled for row 0, 2: stalled until col 13 of row 0
    int rst_row;  // row where reset pulses mid-frame (-1: none)
    int n_end;    // one past the last expected address
    int d_lo;     // dropped address range [d_lo, d_hi)
    int d_hi;
    int done;
    int ovf;
    int peak;
  } scen_t;

  scen_t tbl[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; visible = 1'b0; display_row = 11'(V + 1); display_col = '0;
    capture_en = 1'b0; wr_ready = 1'b0; pixel_in = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic run_frame(input scen_t s);
    for (int row = 0; row < ROWS; row++) begin
      for (int c = 0; c < LINE; c++) begin
        int x;
        x           = c - HB;
        display_row = 11'(row);
        display_col = 12'(c);
        visible     = (row < V) && (c >= HB);
        pixel_in    = visible ? 12'(((row % 64) << 6) | (x % 64)) : 12'h000;
        capture_en  = (s.cap_row >= 0 && row >= s.cap_row) ? 1'b1 : s.cap[0];
        case (s.rdy)
          1:       wr_ready = (row != 0);
          2:       wr_ready = !(row == 0 && c < 13);
          default: wr_ready = 1'b1;
        endcase
        reset = (row == s.rst_row) && (c == 0);
        step();
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    int bad;
    int errs;
    int derr;
    int exp_a[$];

    reset = 1'b1; display_col = '0; display_row = '0; visible = 1'b0;
    pixel_in = '0; capture_en = 1'b0; wr_ready = 1'b0;

    // Reset held with random inputs: every output must read zero.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      display_col = 12'($urandom); display_row = 11'($urandom);
      visible = 1'($urandom); pixel_in = 12'($urandom);
      capture_en = 1'($urandom); wr_ready = 1'($urandom);
      step();
      if (wr_valid || wr_addr != 0 || wr_data != 0 || frame_done || overflow || fifo_level != 0)
        bad++;
    end
    check("reset_outputs", bad, 0);

    // Armed but away from row 0: nothing may be written.
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      display_row = 11'($urandom_range(1, V + 1)); visible = 1'($urandom);
      pixel_in = 12'($urandom); capture_en = 1'b1; wr_ready = 1'($urandom);
      step();
      if (wr_valid || frame_done) bad++;
    end
    check("idle_no_write", bad, 0);

    // First-sample latency and head stability under back-pressure.
    pulse_reset();
    capture_en = 1'b1; wr_ready = 1'b0; display_row = '0;
    for (int c = 0; c < HB; c++) begin
      display_col = 12'(c); visible = 1'b0; step();
    end
    visible = 1'b1; pixel_in = 12'hA5C; step();
    check("lat_not_early", int'(wr_valid), 0);
    pixel_in = 12'h111; step();
    check("lat_valid", int'(wr_valid), 1);
    check("lat_addr", int'(wr_addr), 0);
    check("lat_data", int'(wr_data), 12'hA5C);
    check("lat_level", int'(fifo_level), 1);
    pixel_in = 12'h3F1; step();
    pixel_in = 12'h222; step();
    check("hold_level", int'(fifo_level), 2);
    check("hold_addr", int'(wr_addr), 0);
    check("hold_data", int'(wr_data), 12'hA5C);
    visible = 1'b0; wr_ready = 1'b1; step();
    check("pop_addr", int'(wr_addr), 1);
    check("pop_data", int'(wr_data), 12'h3F1);
    check("pop_level", int'(fifo_level), 1);

    //         pre cap row rdy rst end lo hi done ovf peak
    tbl[0] = '{1,  1,  -1, 0,  -1, 24, 0, 0, 1,   0,  1};
    tbl[1] = '{1,  1,  -1, 1,  -1, 24, 4, 8, 1,   1,  4};
    tbl[2] = '{1,  1,  -1, 2,  -1, 24, 0, 0, 1,   0,  4};
    tbl[3] = '{1,  1,  -1, 0,   2,  8, 0, 0, 0,   0,  1};
    tbl[4] = '{0,  1,  -1, 0,  -1, 24, 0, 0, 1,   0,  1};
    tbl[5] = '{1,  0,   1, 0,  -1,  0, 0, 0, 0,   0,  0};
    tbl[6] = '{0,  1,  -1, 0,  -1, 24, 0, 0, 1,   0,  1};

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].pre_rst != 0) pulse_reset();
      q_addr.delete(); q_data.delete();
      done_cnt = 0; peak = 0;
      run_frame(tbl[t]);

      exp_a.delete();
      for (int a = 0; a < tbl[t].n_end; a++)
        if (a < tbl[t].d_lo || a >= tbl[t].d_hi) exp_a.push_back(a);

      check($sformatf("s%0d_count", t), q_addr.size(), exp_a.size());
      errs = 0; derr = 0;
      for (int i = 0; i < q_addr.size() && i < exp_a.size(); i++) begin
        int a;
        int ex;
        a  = exp_a[i];
        ex = ((2 * (a / (H / 2))) % 64) * 64 + (2 * (a % (H / 2))) % 64;
        if (q_addr[i] != a)  errs++;
        if (q_data[i] != ex) derr++;
      end
      check($sformatf("s%0d_addr_seq", t), errs, 0);
      check($sformatf("s%0d_data", t), derr, 0);
      check($sformatf("s%0d_frame_done", t), done_cnt, tbl[t].done);
      check($sformatf("s%0d_overflow", t), int'(overflow), tbl[t].ovf);
      check($sformatf("s%0d_peak_level", t), peak, tbl[t].peak);
      check($sformatf("s%0d_end_level", t), int'(fifo_level), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
